dfx_data_recv_unpacker: RTL and testbench
=========================================

// Module: dfx_data_recv_unpacker
// PURPOSE
//  Drain stage directly downstream of the DFX data-receive FIFO (1034-bit entries).
//  Pops one entry at a time and splits its 1024-bit payload into OUT_W-bit beats.
//  Presents the beats on a valid/ready stream to the arbiter, tagged with packet
//  framing (sof/eof) and destination ID. Also tracks protocol errors and counts
//  completed packets.
// PARAMETERS
//  OUT_W   256  output beat width; must divide 1024 exactly; NBEATS = 1024/OUT_W
//  CNT_W   16   width of the completed-packet counter
// PORTS
//  clk         in   1        single clock; all logic on rising edge
//  rst_n       in   1        asynchronous, active-HIGH reset (1 = in reset)
//  fifo_empty  in   1        FIFO empty flag
//  fifo_data   in   1034     FIFO read data; valid the cycle after fifo_rd_en
//  fifo_rd_en  out  1        FIFO pop strobe; one-cycle pulse
//  m_valid     out  1        output beat valid
//  m_ready     in   1        downstream accept
//  m_data      out  OUT_W    output beat
//  m_dest      out  8        destination ID of the current packet
//  m_sof       out  1        first beat of a HEAD or SINGLE flit
//  m_eof       out  1        last beat of a TAIL or SINGLE flit
//  proto_err   out  1        sticky framing-error flag
//  pkt_cnt     out  CNT_W    count of completed packets (eof beats accepted), wraps
// BEHAVIOUR
//  Entry format:
//   [1033:1032] type: 00 BODY, 01 HEAD, 10 TAIL, 11 SINGLE
//   [1031:1024] dest
//   [1023:0]    payload
//  Reset (async, rst_n=1):
//   fifo_rd_en=0, m_valid=0, m_data=0, m_dest=0, m_sof=0, m_eof=0,
//   proto_err=0, pkt_cnt=0, in_pkt=0, beat_idx=0, state=IDLE.
//  Mid-operation reset drops the held entry; the FIFO contents are not touched.
//  FSM:
//   IDLE: if !fifo_empty, assert fifo_rd_en for 1 cycle and go to LOAD.
//   LOAD: latch fifo_data into the holding register; beat_idx=0; go to SEND.
//   SEND: m_valid=1.
//    m_data = payload[beat_idx*OUT_W +: OUT_W] (LSB beat first).
//    On m_valid & m_ready, beat_idx increments.
//    On the handshake of beat NBEATS-1:
//     if !fifo_empty, pulse fifo_rd_en and go to LOAD;
//     otherwise go to IDLE.
//  Latency: fifo_rd_en to first m_valid is 2 cycles.
//  Inter-entry bubble is exactly 1 cycle (LOAD), so the maximum throughput is
//  NBEATS beats per NBEATS+1 cycles.
//  Output stability: m_data, m_dest, m_sof and m_eof hold stable while m_valid=1 and m_ready=0.
//  Pop rule: fifo_rd_en is never asserted while fifo_empty=1 or while a beat is
//  pending in SEND (other than on the final handshake).
//  Framing outputs:
//   m_sof=1 only on beat 0 of HEAD/SINGLE.
//   m_eof=1 only on beat NBEATS-1 of TAIL/SINGLE.
//   m_dest loads on LOAD of HEAD/SINGLE; it holds its value for BODY/TAIL.
//  in_pkt tracking:
//   set on accepted eof-less HEAD final beat;
//   cleared on accepted TAIL final beat.
//   SINGLE leaves it 0.
//  Protocol errors:
//   proto_err sets (sticky until reset) when HEAD/SINGLE is loaded with in_pkt=1,
//   or when BODY/TAIL is loaded with in_pkt=0.
//   The flit is still forwarded unchanged.
//   A HEAD received in-packet restarts the packet: m_dest is reloaded.
//  pkt_cnt increments by 1 on each accepted m_eof beat; it wraps 2^CNT_W-1 -> 0.
//  Simultaneous events:
//   The final handshake and a newly non-empty FIFO in the same cycle produce an
//   immediate pop with no IDLE cycle.
//   m_ready is ignored when m_valid=0.
// TESTING
//  1. SINGLE entry, dest=8'h5A, payload=incrementing bytes, m_ready=1
//     -> 4 beats on consecutive cycles; beat0 m_sof=1, beat3 m_eof=1,
//        m_dest=5A, pkt_cnt=1.
//  2. HEAD,BODY,TAIL queued back-to-back, m_ready=1
//     -> 12 beats with exactly one bubble between flits; sof only on beat 0,
//        eof only on beat 11; proto_err=0, pkt_cnt=1.
//  3. Same as test 2 with m_ready toggling randomly
//     -> no beat lost or duplicated; outputs held stable while stalled;
//        fifo_rd_en never asserted with fifo_empty=1.
//  4. BODY first, then HEAD,HEAD,TAIL
//     -> proto_err=1 after the BODY loads and stays 1; all 16 beats forwarded;
//        m_dest follows the second HEAD.
//  5. Reset asserted during beat 2 of a SINGLE
//     -> all outputs 0 immediately; after release the next FIFO entry is
//        popped cleanly and pkt_cnt restarts from 0.
//  6. Preload pkt_cnt near wrap (CNT_W=4), send 2 SINGLEs -> pkt_cnt 15 -> 0 -> 1.

Source files
------------

// File: rtl/dfx_data_recv_unpacker.sv
// rtl/dfx_data_recv_unpacker.sv - drains 1034-bit DFX receive FIFO entries into OUT_W-bit framed beats
module dfx_data_recv_unpacker #(
  parameter int OUT_W = 256,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fifo_empty,
  input  logic [1033:0]    fifo_data,
  output logic             fifo_rd_en,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_data,
  output logic [7:0]       m_dest,
  output logic             m_sof,
  output logic             m_eof,
  output logic             proto_err,
  output logic [CNT_W-1:0] pkt_cnt
);

  localparam int NBEATS = 1024 / OUT_W;
  localparam int IDX_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(NBEATS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;

  localparam logic [1:0] T_HEAD = 2'b01;

  logic [1:0]       state_q, state_d;
  logic [1:0]       type_q;
  logic [1023:0]    payload_q;
  logic [IDX_W-1:0] beat_q;
  logic [7:0]       dest_q;
  logic             in_pkt_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;

  logic             is_send;
  logic             fire;
  logic             last_fire;
  logic [OUT_W-1:0] beats [NBEATS];

  for (genvar g = 0; g < NBEATS; g++) begin : g_split
    assign beats[g] = payload_q[g*OUT_W +: OUT_W];
  end

  assign is_send   = (state_q == ST_SEND);
  assign fire      = is_send && m_ready;
  assign last_fire = fire && (beat_q == LAST_BEAT);

  // type bit 0 marks HEAD/SINGLE (packet start), bit 1 marks TAIL/SINGLE (packet end)
  assign m_valid   = is_send;
  assign m_data    = beats[beat_q];
  assign m_dest    = dest_q;
  assign m_sof     = is_send && type_q[0] && (beat_q == '0);
  assign m_eof     = is_send && type_q[1] && (beat_q == LAST_BEAT);
  assign proto_err = err_q;
  assign pkt_cnt   = cnt_q;

  // Held low during reset so a non-empty FIFO is never popped while the entry would be dropped
  assign fifo_rd_en = !rst_n && !fifo_empty && ((state_q == ST_IDLE) || last_fire);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (!fifo_empty) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_SEND;
      ST_SEND: if (last_fire) state_d = fifo_empty ? ST_IDLE : ST_LOAD;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q   <= ST_IDLE;
      type_q    <= 2'b00;
      payload_q <= '0;
      beat_q    <= '0;
      dest_q    <= 8'h00;
      in_pkt_q  <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_LOAD) begin
        type_q    <= fifo_data[1033:1032];
        payload_q <= fifo_data[1023:0];
        beat_q    <= '0;
        if (fifo_data[1032]) dest_q <= fifo_data[1031:1024];
        // start flit inside a packet, or continuation flit outside one
        if (fifo_data[1032] == in_pkt_q) err_q <= 1'b1;
      end else if (fire) begin
        beat_q <= (beat_q == LAST_BEAT) ? '0 : beat_q + IDX_W'(1);
        if (beat_q == LAST_BEAT) begin
          if (type_q == T_HEAD) in_pkt_q <= 1'b1;
          else if (type_q[1]) in_pkt_q <= 1'b0;
          if (type_q[1]) cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_dfx_data_recv_unpacker.sv
// tb/tb_dfx_data_recv_unpacker.sv - directed self-checking bench for dfx_data_recv_unpacker
module tb_dfx_data_recv_unpacker;
  localparam int OUT_W = 256;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             fifo_empty = 1'b1;
  logic [1033:0]    fifo_data = '0;
  logic             fifo_rd_en;
  logic             m_valid;
  logic             m_ready = 1'b1;
  logic [OUT_W-1:0] m_data;
  logic [7:0]       m_dest;
  logic             m_sof;
  logic             m_eof;
  logic             proto_err;
  logic [CNT_W-1:0] pkt_cnt;

  dfx_data_recv_unpacker #(.OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_dest(m_dest), .m_sof(m_sof), .m_eof(m_eof), .proto_err(proto_err), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] d;
    logic [7:0]   dest;
    logic         sof;
    logic         eof;
  } beat_t;

  logic [1033:0] fifo_q[$];
  beat_t         exp_q[$];
  int            hs_cyc[$];
  int            cyc = 0;
  int            rd_cyc = -1;
  int            v_cyc = -1;
  logic [7:0]    dest_m = 8'h00;
  bit            rnd_ready = 1'b0;
  int            n_tests = 0;
  int            n_fail = 0;

  logic          prev_hold = 1'b0;
  logic [255:0]  prev_d;
  logic [7:0]    prev_dest;
  logic          prev_sof, prev_eof;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1033:0] mk_entry(input logic [1:0] t, input logic [7:0] d, input logic [7:0] seed);
    logic [1033:0] e;
    e[1033:1032] = t;
    e[1031:1024] = d;
    for (int j = 0; j < 128; j++) e[j*8 +: 8] = 8'(seed + j);
    return e;
  endfunction

  task automatic add_exp(input logic [1033:0] e);
    beat_t b;
    for (int i = 0; i < 4; i++) begin
      if (i == 0 && e[1032]) dest_m = e[1031:1024];
      b.d    = e[i*256 +: 256];
      b.dest = dest_m;
      b.sof  = e[1032] && (i == 0);
      b.eof  = e[1033] && (i == 3);
      exp_q.push_back(b);
    end
  endtask

  task automatic push(input logic [1033:0] e);
    fifo_q.push_back(e);
    fifo_empty = 1'b0;
    add_exp(e);
  endtask

  task automatic sync;
    @(posedge clk);
    #3;
  endtask

  task automatic do_reset;
    sync();
    rst_n = 1'b1;
    fifo_q.delete();
    fifo_empty = 1'b1;
    exp_q.delete();
    hs_cyc.delete();
    dest_m = 8'h00;
    rd_cyc = -1;
    v_cyc = -1;
    sync();
    rst_n = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int  n;
    bit  done;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      @(negedge clk);
      #1;
      n++;
      done = (fifo_q.size() == 0) && (exp_q.size() == 0) && !m_valid;
    end
    check_eq("idle_reached", done, 1'b1);
  endtask

  // FIFO model: pop strobe sampled mid-cycle, read data appears just after the popping edge
  initial begin
    bit rd_seen;
    forever begin
      @(negedge clk);
      rd_seen = fifo_rd_en;
      if (rd_seen) begin
        check_eq("pop_nonempty", fifo_empty, 1'b0);
        if (rd_cyc < 0) rd_cyc = cyc;
      end
      @(posedge clk);
      #1;
      if (rd_seen && fifo_q.size() > 0) begin
        fifo_data  = fifo_q.pop_front();
        fifo_empty = (fifo_q.size() == 0);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_ready) m_ready = 1'($urandom_range(0, 1));
    end
  end

  // Output monitor: scoreboard compare on each handshake, stability while stalled
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          check_eq("hold_valid", m_valid, 1'b1);
          check_eq("hold_data", m_data, prev_d);
          check_eq("hold_dest", m_dest, prev_dest);
          check_eq("hold_sof", m_sof, prev_sof);
          check_eq("hold_eof", m_eof, prev_eof);
        end
        if (m_valid && v_cyc < 0) v_cyc = cyc;
        if (m_valid && m_ready) begin
          check_eq("beat_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq("beat_data", m_data, e.d);
            check_eq("beat_dest", m_dest, e.dest);
            check_eq("beat_sof", m_sof, e.sof);
            check_eq("beat_eof", m_eof, e.eof);
          end
          hs_cyc.push_back(cyc);
        end
        prev_hold = m_valid && !m_ready;
        prev_d    = m_data;
        prev_dest = m_dest;
        prev_sof  = m_sof;
        prev_eof  = m_eof;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state, with an entry already waiting in the FIFO
    sync();
    push(mk_entry(2'b11, 8'h5A, 8'h00));
    #1;
    check_eq("rst_rd_en", fifo_rd_en, 1'b0);
    check_eq("rst_valid", m_valid, 1'b0);
    check_eq("rst_data", m_data, '0);
    check_eq("rst_dest", m_dest, 8'h00);
    check_eq("rst_sof", m_sof, 1'b0);
    check_eq("rst_eof", m_eof, 1'b0);
    check_eq("rst_err", proto_err, 1'b0);
    check_eq("rst_cnt", pkt_cnt, 4'd0);

    // Test 1: SINGLE, back-to-back beats
    sync();
    rst_n = 1'b0;
    wait_idle(200);
    check_eq("t1_latency", v_cyc - rd_cyc, 2);
    check_eq("t1_beats", hs_cyc.size(), 4);
    for (int i = 1; i < 4 && i < hs_cyc.size(); i++) check_eq("t1_consec", hs_cyc[i] - hs_cyc[0], i);
    check_eq("t1_dest", m_dest, 8'h5A);
    check_eq("t1_cnt", pkt_cnt, 4'd1);
    check_eq("t1_err", proto_err, 1'b0);

    // Test 2: HEAD, BODY, TAIL with one bubble between flits
    do_reset();
    push(mk_entry(2'b01, 8'hC3, 8'h10));
    push(mk_entry(2'b00, 8'h77, 8'h40));
    push(mk_entry(2'b10, 8'h88, 8'h80));
    wait_idle(300);
    check_eq("t2_beats", hs_cyc.size(), 12);
    for (int i = 1; i < 12 && i < hs_cyc.size(); i++) check_eq("t2_spacing", hs_cyc[i] - hs_cyc[0], i + i / 4);
    check_eq("t2_err", proto_err, 1'b0);
    check_eq("t2_cnt", pkt_cnt, 4'd1);
    check_eq("t2_dest", m_dest, 8'hC3);

    // Test 3: same packet under random backpressure
    do_reset();
    rnd_ready = 1'b1;
    push(mk_entry(2'b01, 8'h3C, 8'h21));
    push(mk_entry(2'b00, 8'h00, 8'h52));
    push(mk_entry(2'b10, 8'h00, 8'h93));
    wait_idle(2000);
    rnd_ready = 1'b0;
    m_ready = 1'b1;
    check_eq("t3_beats", hs_cyc.size(), 12);
    check_eq("t3_err", proto_err, 1'b0);
    check_eq("t3_cnt", pkt_cnt, 4'd1);

    // Test 4: BODY out of packet, then HEAD, HEAD, TAIL
    do_reset();
    push(mk_entry(2'b00, 8'hEE, 8'h05));
    push(mk_entry(2'b01, 8'h11, 8'h06));
    push(mk_entry(2'b01, 8'h22, 8'h07));
    push(mk_entry(2'b10, 8'hFF, 8'h08));
    begin
      int n;
      n = 0;
      while (!m_valid && n < 50) begin
        @(negedge clk);
        #1;
        n++;
      end
    end
    check_eq("t4_err_early", proto_err, 1'b1);
    wait_idle(300);
    check_eq("t4_beats", hs_cyc.size(), 16);
    check_eq("t4_err_sticky", proto_err, 1'b1);
    check_eq("t4_dest", m_dest, 8'h22);
    check_eq("t4_cnt", pkt_cnt, 4'd1);

    // Test 5: reset while beat 2 of a SINGLE is presented
    do_reset();
    push(mk_entry(2'b11, 8'h33, 8'hA0));
    push(mk_entry(2'b11, 8'h44, 8'hB0));
    begin
      int n;
      n = 0;
      while (hs_cyc.size() < 2 && n < 50) begin
        @(posedge clk);
        #2;
        n++;
      end
    end
    check_eq("t5_rst_point", hs_cyc.size(), 2);
    rst_n = 1'b1;
    #1;
    check_eq("t5_rd_en", fifo_rd_en, 1'b0);
    check_eq("t5_valid", m_valid, 1'b0);
    check_eq("t5_data", m_data, '0);
    check_eq("t5_dest", m_dest, 8'h00);
    check_eq("t5_sof", m_sof, 1'b0);
    check_eq("t5_eof", m_eof, 1'b0);
    check_eq("t5_cnt0", pkt_cnt, 4'd0);
    exp_q.delete();
    hs_cyc.delete();
    dest_m = 8'h00;
    add_exp(mk_entry(2'b11, 8'h44, 8'hB0));
    sync();
    rst_n = 1'b0;
    wait_idle(200);
    check_eq("t5_beats", hs_cyc.size(), 4);
    check_eq("t5_cnt", pkt_cnt, 4'd1);
    check_eq("t5_dest_after", m_dest, 8'h44);
    check_eq("t5_err", proto_err, 1'b0);

    // Test 6: counter wrap with a 4-bit counter
    do_reset();
    for (int i = 0; i < 15; i++) push(mk_entry(2'b11, 8'(i), 8'(i * 3)));
    wait_idle(1000);
    check_eq("t6_cnt15", pkt_cnt, 4'd15);
    sync();
    push(mk_entry(2'b11, 8'h99, 8'h01));
    wait_idle(200);
    check_eq("t6_cnt_wrap", pkt_cnt, 4'd0);
    sync();
    push(mk_entry(2'b11, 8'h9A, 8'h02));
    wait_idle(200);
    check_eq("t6_cnt1", pkt_cnt, 4'd1);
    check_eq("t6_err", proto_err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
